data_memory_arbiter: RTL and testbench
======================================

DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 SHALL have one clock and one reset: clock port clk; reset port rst, synchronous, active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 reqN_valid  input  1  requester N (N=0,1) has an access pending.
REQ-005 reqN_write  input  1  1=store, 0=load.
REQ-006 reqN_addr  input  8  word address.
REQ-007 reqN_wdata  input  64  store data.
REQ-008 reqN_ready  output  1  arbiter accepts requester N this cycle.
REQ-009 respN_valid  output  1  one-cycle completion pulse to requester N.
REQ-010 respN_rdata  output  64  load result for requester N.
REQ-011 mem_address  output  8  to data_memory memaddress.
REQ-012 mem_inputdata  output  64  to data_memory inputdata.
REQ-013 mem_ismemwrite  output  1  to data_memory ismemwrite.
REQ-014 mem_outputdata  input  64  from data_memory outputdata (combinational read).
REQ-015 acc_countN  output  16  completed accesses by requester N.

Function
REQ-016 FSM SHALL have states IDLE and SERVE.
REQ-017 In IDLE, with exactly one reqN_valid high, reqN_ready SHALL be 1 (combinational) for that requester only.
REQ-018 In IDLE, with both valid, ready SHALL go to the requester not granted last (last_grant register); the other's ready SHALL be 0.
REQ-019 A transfer SHALL occur only on a rising edge with reqN_valid=1 and reqN_ready=1; on it: latch write/addr/wdata/requester id, update last_grant to N, go to SERVE.
REQ-020 Requesters MAY drop valid while ready=0; no state changes until a transfer.
REQ-021 reqN_ready SHALL be 0 in SERVE.
REQ-022 In SERVE, mem_address/mem_inputdata SHALL drive latched values; mem_ismemwrite SHALL equal the latched write flag.
REQ-023 Outside SERVE, mem_address=0, mem_inputdata=0, mem_ismemwrite=0.
REQ-024 At the end of SERVE: load -> respN_rdata <= mem_outputdata; store -> respN_rdata unchanged; respN_valid <= 1 for one cycle; FSM -> IDLE.
REQ-025 Latency: accept at edge T, memory access in cycle T..T+1, respN_valid high in cycle T+1..T+2; peak throughput one access per 2 cycles.
REQ-026 The cycle with respN_valid high is an IDLE cycle; a new request SHALL be acceptable in it (back-to-back).
REQ-027 respN_rdata SHALL hold until the next load completion for that requester.
REQ-028 acc_countN SHALL increment on each completion for requester N, saturating at 16'hFFFF.
REQ-029 Only one respN_valid SHALL be high in any cycle.

Reset
REQ-030 While rst=1, mem_ismemwrite SHALL be forced 0 combinationally, also in SERVE (aborted access writes nothing).
REQ-031 On an edge with rst=1: state=IDLE, last_grant=1 (requester 0 wins first tie), respN_valid=0, respN_rdata=0, acc_countN=0, latched request=0.
REQ-032 An access in progress at reset SHALL be dropped with no response.

Verification
REQ-033 Single load: mem[3]=64'h7, req0 load addr 3 -> ready0 in accept cycle, mem_address=3 in SERVE, resp0_valid pulse next cycle, resp0_rdata=64'h7, acc_count0=1.
REQ-034 Store then load: req1 store 64'hA5 to addr 9, then load addr 9 -> mem_ismemwrite=1 exactly one cycle, load returns 64'hA5, acc_count1=2.
REQ-035 Tie after reset: both valid -> req0 served first, then req1; both held valid for 4 accesses -> grants 0,1,0,1.
REQ-036 Back-to-back: req0 valid continuously, 3 loads -> accepts in cycles 0,2,4; resp0_valid in cycles 2,4,6.
REQ-037 Reset mid-access: rst=1 during SERVE of a store to addr 5 -> mem_ismemwrite=0, mem[5] unchanged, no resp, counters 0, FSM IDLE.
REQ-038 Saturation: preload acc_count0 via 65535 completions (or forced) -> one more access leaves acc_count0=16'hFFFF.

Source files
------------

// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a single-port data memory.
// The arbiter takes the slave modport and the requesters/memory take the master modport.
interface data_memory_arbiter_if;
   logic        req0_valid;
   logic        req0_write;
   logic [7:0]  req0_addr;
   logic [63:0] req0_wdata;
   logic        req0_ready;
   logic        resp0_valid;
   logic [63:0] resp0_rdata;

   logic        req1_valid;
   logic        req1_write;
   logic [7:0]  req1_addr;
   logic [63:0] req1_wdata;
   logic        req1_ready;
   logic        resp1_valid;
   logic [63:0] resp1_rdata;

   logic [7:0]  mem_address;
   logic [63:0] mem_inputdata;
   logic        mem_ismemwrite;
   logic [63:0] mem_outputdata;

   logic [15:0] acc_count0;
   logic [15:0] acc_count1;

   modport slave (
      input  req0_valid, req0_write, req0_addr, req0_wdata,
      output req0_ready, resp0_valid, resp0_rdata,
      input  req1_valid, req1_write, req1_addr, req1_wdata,
      output req1_ready, resp1_valid, resp1_rdata,
      output mem_address, mem_inputdata, mem_ismemwrite,
      input  mem_outputdata,
      output acc_count0, acc_count1
   );

   modport master (
      output req0_valid, req0_write, req0_addr, req0_wdata,
      input  req0_ready, resp0_valid, resp0_rdata,
      output req1_valid, req1_write, req1_addr, req1_wdata,
      input  req1_ready, resp1_valid, resp1_rdata,
      input  mem_address, mem_inputdata, mem_ismemwrite,
      output mem_outputdata,
      input  acc_count0, acc_count1
   );
endinterface

// File: rtl/data_memory_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each access takes one SERVE cycle; the completion pulse lands in the following IDLE cycle.
module data_memory_arbiter (
   input logic                  clk,
   input logic                  rst,
   data_memory_arbiter_if.slave bus
);

   typedef enum logic {IDLE, SERVE} state_t;

   state_t      r_state;
   logic        r_lastGrant;
   logic        r_write;
   logic        r_id;
   logic [7:0]  r_addr;
   logic [63:0] r_wdata;
   logic        r_respValid0;
   logic        r_respValid1;
   logic [63:0] r_respRdata0;
   logic [63:0] r_respRdata1;
   logic [15:0] r_accCount0;
   logic [15:0] r_accCount1;

   logic        w_ready0;
   logic        w_ready1;
   logic        w_serve;

   // On a tie the requester that was not granted last wins.
   always_comb begin
      w_serve  = (r_state == SERVE);
      w_ready0 = (r_state == IDLE) && bus.req0_valid && (!bus.req1_valid || r_lastGrant);
      w_ready1 = (r_state == IDLE) && bus.req1_valid && (!bus.req0_valid || !r_lastGrant);
   end

   assign bus.req0_ready     = w_ready0;
   assign bus.req1_ready     = w_ready1;
   assign bus.mem_address    = w_serve ? r_addr  : 8'd0;
   assign bus.mem_inputdata  = w_serve ? r_wdata : 64'd0;
   assign bus.mem_ismemwrite = w_serve && r_write && !rst;
   assign bus.resp0_valid    = r_respValid0;
   assign bus.resp1_valid    = r_respValid1;
   assign bus.resp0_rdata    = r_respRdata0;
   assign bus.resp1_rdata    = r_respRdata1;
   assign bus.acc_count0     = r_accCount0;
   assign bus.acc_count1     = r_accCount1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_lastGrant  <= 1'b1;
         r_write      <= 1'b0;
         r_id         <= 1'b0;
         r_addr       <= 8'd0;
         r_wdata      <= 64'd0;
         r_respValid0 <= 1'b0;
         r_respValid1 <= 1'b0;
         r_respRdata0 <= 64'd0;
         r_respRdata1 <= 64'd0;
         r_accCount0  <= 16'd0;
         r_accCount1  <= 16'd0;
      end else begin
         r_respValid0 <= 1'b0;
         r_respValid1 <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_ready0) begin
                  r_write     <= bus.req0_write;
                  r_addr      <= bus.req0_addr;
                  r_wdata     <= bus.req0_wdata;
                  r_id        <= 1'b0;
                  r_lastGrant <= 1'b0;
                  r_state     <= SERVE;
               end else if (w_ready1) begin
                  r_write     <= bus.req1_write;
                  r_addr      <= bus.req1_addr;
                  r_wdata     <= bus.req1_wdata;
                  r_id        <= 1'b1;
                  r_lastGrant <= 1'b1;
                  r_state     <= SERVE;
               end
            end
            SERVE: begin
               // Stores leave the previous load result visible to the requester.
               if (!r_id) begin
                  r_respValid0 <= 1'b1;
                  if (!r_write) r_respRdata0 <= bus.mem_outputdata;
                  if (r_accCount0 != 16'hFFFF) r_accCount0 <= r_accCount0 + 16'd1;
               end else begin
                  r_respValid1 <= 1'b1;
                  if (!r_write) r_respRdata1 <= bus.mem_outputdata;
                  if (r_accCount1 != 16'hFFFF) r_accCount1 <= r_accCount1 + 16'd1;
               end
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios plus random traffic against a
// transaction-level model of grants, memory contents, responses and counters.
module tb_data_memory_arbiter;

   logic clk;
   logic rst;

   data_memory_arbiter_if bus ();

   data_memory_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [63:0] mem    [256];
   logic [63:0] refMem [256];

   assign bus.mem_outputdata = mem[bus.mem_address];

   int checks   = 0;
   int failures = 0;

   // Reference model state: an outstanding access (if any) and what each requester has seen.
   bit          mBusy;
   bit          mLastGrant;
   bit          mWrite;
   int          mId;
   logic [7:0]  mAddr;
   logic [63:0] mWdata;
   bit          mRespValid [2];
   logic [63:0] mRdata     [2];
   int          mCount     [2];

   task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic modelReset();
      mBusy      = 0;
      mLastGrant = 1;
      mWrite     = 0;
      mId        = 0;
      mAddr      = 0;
      mWdata     = 0;
      for (int i = 0; i < 2; i++) begin
         mRespValid[i] = 0;
         mRdata[i]     = 0;
         mCount[i]     = 0;
      end
   endtask

   // One clock cycle: drive inputs, check combinational outputs, advance the model, check registers.
   task automatic applyStimulus(input bit r,
                                input bit v0, input bit w0, input logic [7:0] a0, input logic [63:0] d0,
                                input bit v1, input bit w1, input logic [7:0] a1, input logic [63:0] d1);
      int          g;
      bit          wrCap;
      logic [7:0]  wrAddr;
      logic [63:0] wrData;
      @(negedge clk);
      rst            = r;
      bus.req0_valid = v0;
      bus.req0_write = w0;
      bus.req0_addr  = a0;
      bus.req0_wdata = d0;
      bus.req1_valid = v1;
      bus.req1_write = w1;
      bus.req1_addr  = a1;
      bus.req1_wdata = d1;
      #1;
      g = -1;
      if (!mBusy) begin
         if (v0 && v1) g = mLastGrant ? 0 : 1;
         else if (v0)  g = 0;
         else if (v1)  g = 1;
      end
      checkOutput("ready0", bus.req0_ready, 64'(g == 0));
      checkOutput("ready1", bus.req1_ready, 64'(g == 1));
      checkOutput("memAddr", bus.mem_address, mBusy ? 64'(mAddr) : 64'd0);
      checkOutput("memData", bus.mem_inputdata, mBusy ? mWdata : 64'd0);
      checkOutput("memWrite", bus.mem_ismemwrite, 64'(mBusy && mWrite && !r));
      wrCap  = bus.mem_ismemwrite;
      wrAddr = bus.mem_address;
      wrData = bus.mem_inputdata;

      if (r) begin
         modelReset();
      end else if (mBusy) begin
         if (mWrite) refMem[mAddr] = mWdata;
         else        mRdata[mId] = refMem[mAddr];
         mRespValid[mId]     = 1;
         mRespValid[1 - mId] = 0;
         if (mCount[mId] < 65535) mCount[mId]++;
         mBusy = 0;
      end else begin
         mRespValid[0] = 0;
         mRespValid[1] = 0;
         if (g >= 0) begin
            mBusy      = 1;
            mId        = g;
            mLastGrant = (g == 1);
            mWrite     = (g == 0) ? w0 : w1;
            mAddr      = (g == 0) ? a0 : a1;
            mWdata     = (g == 0) ? d0 : d1;
         end
      end

      @(posedge clk);
      #1;
      if (wrCap) mem[wrAddr] = wrData;
      checkOutput("resp0Valid", bus.resp0_valid, 64'(mRespValid[0]));
      checkOutput("resp1Valid", bus.resp1_valid, 64'(mRespValid[1]));
      checkOutput("resp0Rdata", bus.resp0_rdata, mRdata[0]);
      checkOutput("resp1Rdata", bus.resp1_rdata, mRdata[1]);
      checkOutput("accCount0", bus.acc_count0, 64'(mCount[0]));
      checkOutput("accCount1", bus.acc_count1, 64'(mCount[1]));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 8'd0, 64'd0, 0, 0, 8'd0, 64'd0);
   endtask

   initial begin
      rst            = 1'b1;
      bus.req0_valid = 1'b0;
      bus.req0_write = 1'b0;
      bus.req0_addr  = 8'd0;
      bus.req0_wdata = 64'd0;
      bus.req1_valid = 1'b0;
      bus.req1_write = 1'b0;
      bus.req1_addr  = 8'd0;
      bus.req1_wdata = 64'd0;
      for (int i = 0; i < 256; i++) begin
         mem[i]    = {32'hC0DE_0000 + 32'(i), 32'(i) * 32'h0101_0101};
         refMem[i] = mem[i];
      end
      mem[3]    = 64'h7;
      refMem[3] = 64'h7;
      modelReset();

      applyStimulus(1, 0, 0, 8'd0, 64'd0, 0, 0, 8'd0, 64'd0);
      applyStimulus(1, 0, 0, 8'd0, 64'd0, 0, 0, 8'd0, 64'd0);

      // Single load from address 3.
      applyStimulus(0, 1, 0, 8'd3, 64'd0, 0, 0, 8'd0, 64'd0);
      idle(2);

      // Store then load on requester 1.
      applyStimulus(0, 0, 0, 8'd0, 64'd0, 1, 1, 8'd9, 64'hA5);
      idle(1);
      applyStimulus(0, 0, 0, 8'd0, 64'd0, 1, 0, 8'd9, 64'd0);
      idle(2);
      checkOutput("mem9", mem[9], 64'hA5);

      // Tie after reset: both held valid over four accesses.
      applyStimulus(1, 0, 0, 8'd0, 64'd0, 0, 0, 8'd0, 64'd0);
      for (int i = 0; i < 8; i++)
         applyStimulus(0, 1, 0, 8'd4, 64'd0, 1, 0, 8'd6, 64'd0);
      idle(2);

      // Back-to-back loads from requester 0.
      for (int i = 0; i < 6; i++)
         applyStimulus(0, 1, 0, 8'(10 + i), 64'd0, 0, 0, 8'd0, 64'd0);
      idle(2);

      // Reset during the SERVE cycle of a store to address 5.
      applyStimulus(1, 0, 0, 8'd0, 64'd0, 0, 0, 8'd0, 64'd0);
      applyStimulus(0, 1, 1, 8'd5, 64'hDEAD_BEEF_0000_0005, 0, 0, 8'd0, 64'd0);
      applyStimulus(1, 0, 0, 8'd0, 64'd0, 0, 0, 8'd0, 64'd0);
      idle(2);
      checkOutput("mem5", mem[5], refMem[5]);

      // Random traffic, including valid drops and occasional reset.
      for (int i = 0; i < 400; i++)
         applyStimulus(($urandom_range(0, 49) == 0),
                       1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), {$urandom, $urandom},
                       1'($urandom), 1'($urandom), 8'($urandom_range(0, 15)), {$urandom, $urandom});
      idle(2);

      // Counter saturation, starting just below the limit.
      @(negedge clk);
      force dut.r_accCount0 = 16'hFFFE;
      #1;
      release dut.r_accCount0;
      mCount[0] = 16'hFFFE;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(0, 1, 0, 8'd3, 64'd0, 0, 0, 8'd0, 64'd0);
         idle(1);
      end
      checkOutput("satCount0", bus.acc_count0, 64'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
